uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: number of data bits per frame, LSB first.
REQ-002 SHALL have parameter SAMPLE_RATE, default 16: ticks per bit period; even, at least 4.
REQ-003 SHALL have port clock, input, 1: system clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-006 SHALL have port tick, input, 1: one-cycle oversample strobe from the baud rate generator.
REQ-007 SHALL have port start_rx, output, 1: one-cycle pulse that re-phases the baud rate generator at start-bit detection.
REQ-008 SHALL have port data, output, DATA_BITS: last accepted byte.
REQ-009 SHALL have port data_valid, output, 1: data holds an unconsumed byte.
REQ-010 SHALL have port data_ready, input, 1: consumer accepts data this cycle.
REQ-011 SHALL have port framing_error, output, 1: one-cycle pulse when the stop bit samples 0.
REQ-012 SHALL have port overrun, output, 1: one-cycle pulse when a completed byte is dropped.
REQ-013 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer (rx_s); both flops reset to 1, adding 2 cycles of latency.
REQ-015 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-016 IDLE: when rx_s==0, SHALL pulse start_rx for exactly one cycle, clear tick_cnt and go to START in the same cycle.
REQ-017 tick_cnt SHALL increment only on cycles with tick==1; cycles without tick SHALL change no counter.
REQ-018 START: on the tick where tick_cnt==SAMPLE_RATE/2-1, SHALL sample rx_s.
REQ-019 If that START sample is 0, SHALL go to DATA with tick_cnt=0 and bit_cnt=0.
REQ-020 If that START sample is 1 (false start), SHALL return to IDLE with no output change.
REQ-021 DATA: on the tick where tick_cnt==SAMPLE_RATE-1, SHALL shift rx_s into the MSB of the shift register (right shift), clear tick_cnt and increment bit_cnt.
REQ-022 DATA SHALL go to STOP after the sample where bit_cnt reaches DATA_BITS.
REQ-023 STOP: on the tick where tick_cnt==SAMPLE_RATE-1, SHALL sample rx_s.
REQ-024 If the STOP sample is 1, SHALL complete the byte and go to IDLE.
REQ-025 If the STOP sample is 0, SHALL discard the byte, pulse framing_error and go to BREAK.
REQ-026 BREAK SHALL remain until rx_s==1, then go to IDLE; a line held low SHALL NOT start a new frame.
REQ-027 On byte completion with data_valid==0, or with data_valid==1 and data_ready==1 in the same cycle, SHALL load data and set data_valid=1 on the next edge.
REQ-028 On byte completion with data_valid==1 and data_ready==0, SHALL keep the old data, drop the new byte and pulse overrun for one cycle.
REQ-029 data_valid SHALL clear on the edge after a cycle with data_valid&&data_ready, unless REQ-027 reloads it.
REQ-030 data SHALL be stable while data_valid==1 and data_ready==0.
REQ-031 rx transitions during DATA or STOP between sample points SHALL be ignored.

Reset
REQ-032 reset SHALL take priority over all other inputs and abort any frame in progress.
REQ-033 After reset: state IDLE, rx_s=1, tick_cnt=0, bit_cnt=0, shift register=0, data=0.
REQ-034 After reset: data_valid=0, start_rx=0, framing_error=0, overrun=0, busy=0.

Verification (tick every 4 cycles, bit period = 16 ticks)
REQ-035 Frame 0xA5 with stop=1 -> start_rx pulses once, data=0xA5, data_valid=1 held until data_ready, no error pulses.
REQ-036 rx low for 3 ticks, then high -> START aborts to IDLE; data_valid, framing_error and overrun stay 0.
REQ-037 Frame 0x81 with stop=0, line then held low for 40 ticks -> one framing_error pulse, data_valid=0, busy=1 until rx high, no second start_rx.
REQ-038 Frames 0x3C then 0xC3 back-to-back, data_ready=0 -> data=0x3C, one overrun pulse; repeat with data_ready=1 in the 0xC3 completion cycle -> data=0xC3, no overrun.
REQ-039 reset asserted after 4 DATA bits -> all outputs reset next edge; following frame 0x5A received cleanly.

Source files
------------

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: synchronizes rx, frames start/data/stop bits on
// tick strobes and hands completed bytes to a valid/ready consumer.
module uart_receiver #(
  parameter int DATA_BITS   = 8,
  parameter int SAMPLE_RATE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 tick,
  output logic                 start_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);
  localparam int TW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(SAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 overrun_q, overrun_d;
  logic                 byte_done;
  logic [DATA_BITS:0]   shift_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= IDLE;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      rx_meta_q       <= rx;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  // New bit enters at the MSB so the first (LSB) bit ends up at bit 0.
  assign shift_in = {rx_s_q, shift_q};

  always_comb begin
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    start_rx        = 1'b0;
    framing_error_d = 1'b0;
    byte_done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          start_rx   = 1'b1;
          tick_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            if (!rx_s_q) begin
              bit_cnt_d = '0;
              state_d   = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == FULL_M1) begin
            shift_d    = shift_in[DATA_BITS:1];
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == LAST_BIT) state_d = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            if (rx_s_q) begin
              byte_done = 1'b1;
              state_d   = IDLE;
            end else begin
              framing_error_d = 1'b1;
              state_d         = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      BREAK: begin
        // A held-low line must return high before another start is honoured.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d       = data_q;
    data_valid_d = data_valid_q && !data_ready;
    overrun_d    = 1'b0;
    if (byte_done) begin
      if (!data_valid_q || data_ready) begin
        data_d       = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != IDLE);

endmodule
